// File: rtl/tcu_input_frame_buffer.sv
// Serial-to-parallel input frame buffer in front of the TCU I/O controller.
// It fills a shadow frame one word at a time and copies it to the CUT inputs on load_input.
module tcu_input_frame_buffer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH_INPUT = 48,
  parameter int CNT_W       = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          val_input,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          re_i,
  input  logic                          load_input,
  input  logic                          clr_err,
  output logic                          in_ready,
  output logic [DATA_W*DEPTH_INPUT-1:0] cut_data,
  output logic                          cut_valid,
  output logic                          frame_full,
  output logic [CNT_W-1:0]              word_cnt,
  output logic                          last_word,
  output logic                          overrun
);

  // Handshake: a word moves only on a cycle with val_input && in_ready. in_ready
  // does not depend on val_input. If val_input is high while in_ready is low,
  // the word is dropped and the sticky overrun flag is set.

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH_INPUT - 1);

  state_t                          state, state_nxt;
  logic                            acc;
  logic                            last_hit;
  logic [DATA_W-1:0]               shadow [DEPTH_INPUT];
  logic [DATA_W*DEPTH_INPUT-1:0]   shadow_flat;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (last_hit)   state_nxt = FULL;
      FULL: if (load_input) state_nxt = FILL;
      default:              state_nxt = FILL;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    in_ready = re_i && ((state == FILL) || load_input);
    acc      = val_input && in_ready;
    last_hit = acc && (state == FILL) && (word_cnt == LAST_SLOT);
  end

  assign frame_full = (state == FULL);

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < DEPTH_INPUT; k++) begin
      shadow_flat[k*DATA_W +: DATA_W] = shadow[k];
    end
  end

  // Slot counter wraps after the last word. In FULL it is already 0, so a word
  // accepted together with load_input lands in slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt  <= '0;
      last_word <= 1'b0;
    end else begin
      last_word <= last_hit;
      if (acc) word_cnt <= (word_cnt == LAST_SLOT) ? '0 : word_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH_INPUT; k++) shadow[k] <= '0;
    end else if (acc) begin
      shadow[word_cnt] <= data_in;
    end
  end

  // The transfer samples the pre-edge shadow, so a same-cycle slot-0 write is
  // not part of the copied frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cut_data  <= '0;
      cut_valid <= 1'b0;
    end else if (load_input) begin
      cut_data  <= shadow_flat;
      cut_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        overrun <= 1'b0;
    else if (val_input && !in_ready) overrun <= 1'b1;
    else if (clr_err)                overrun <= 1'b0;
  end

endmodule

// File: tb/tb_tcu_input_frame_buffer.sv
// Randomized bench for tcu_input_frame_buffer.
// A frame-level reference model (a word queue plus a shadow image) predicts every output.
module tb_tcu_input_frame_buffer;

  localparam int DW    = 8;
  localparam int D     = 48;
  localparam int CW    = 6;
  localparam int CUT_W = DW * D;

  logic             clk;
  logic             rst;
  logic             val_input;
  logic [DW-1:0]    data_in;
  logic             re_i;
  logic             load_input;
  logic             clr_err;
  logic             in_ready;
  logic [CUT_W-1:0] cut_data;
  logic             cut_valid;
  logic             frame_full;
  logic [CW-1:0]    word_cnt;
  logic             last_word;
  logic             overrun;

  tcu_input_frame_buffer #(.DATA_W(DW), .DEPTH_INPUT(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .val_input(val_input), .data_in(data_in), .re_i(re_i),
    .load_input(load_input), .clr_err(clr_err), .in_ready(in_ready), .cut_data(cut_data),
    .cut_valid(cut_valid), .frame_full(frame_full), .word_cnt(word_cnt),
    .last_word(last_word), .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    m_shadow [D];
  logic [CUT_W-1:0] m_cut;
  bit               m_cut_valid;
  bit               m_full;
  bit               m_ovr;
  int               acc_since;
  int               n_checks;
  int               n_errors;

  task automatic check_eq(input string tag, input logic [CUT_W-1:0] got,
                          input logic [CUT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CUT_W-1:0] pack_shadow();
    logic [CUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[k*DW +: DW] = m_shadow[k];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < D; k++) m_shadow[k] = '0;
    m_cut = '0; m_cut_valid = 0; m_full = 0; m_ovr = 0; acc_since = 0;
  endtask

  // Asynchronous reset, checked while still asserted.
  task automatic do_reset();
    @(negedge clk);
    val_input = 0; data_in = '0; re_i = 0; load_input = 0; clr_err = 0;
    rst = 0;
    #1;
    model_reset();
    check_eq("rst_cut_data", cut_data, '0);
    check_eq("rst_cut_valid", cut_valid, 0);
    check_eq("rst_frame_full", frame_full, 0);
    check_eq("rst_word_cnt", word_cnt, 0);
    check_eq("rst_last_word", last_word, 0);
    check_eq("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1;
  endtask

  // One clock of stimulus: drive at negedge, check in_ready, update the model at
  // posedge, then check the registered outputs.
  task automatic drive(input bit val, input logic [DW-1:0] d, input bit re,
                       input bit load, input bit clr);
    bit exp_ready, acc, last_exp;
    @(negedge clk);
    val_input = val; data_in = d; re_i = re; load_input = load; clr_err = clr;
    #1;
    exp_ready = re && (!m_full || load);
    acc = val && exp_ready;
    check_eq("in_ready", in_ready, exp_ready);
    @(posedge clk);
    last_exp = 0;
    if (load) begin
      m_cut = pack_shadow();
      m_cut_valid = 1;
    end
    if (val && !exp_ready) m_ovr = 1;
    else if (clr)          m_ovr = 0;
    if (load && m_full) m_full = 0;
    if (acc) begin
      m_shadow[exp_q.size()] = d;
      exp_q.push_back(d);
      acc_since++;
      if (exp_q.size() == D) begin
        exp_q.delete();
        m_full = 1;
        last_exp = 1;
      end
    end
    #1;
    check_eq("frame_full", frame_full, m_full);
    check_eq("word_cnt", word_cnt, exp_q.size());
    check_eq("last_word", last_word, last_exp);
    check_eq("overrun", overrun, m_ovr);
    check_eq("cut_valid", cut_valid, m_cut_valid);
    check_eq("cut_data", cut_data, m_cut);
    if (last_word) begin
      check_eq("accepts_per_frame", acc_since, D);
      acc_since = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 1, 0, 0);
  endtask

  initial begin
    int guard;
    n_checks = 0; n_errors = 0;
    rst = 0; val_input = 0; data_in = '0; re_i = 0; load_input = 0; clr_err = 0;
    model_reset();
    do_reset();

    // Counting frame, then transfer
    for (int k = 0; k < D; k++) drive(1, DW'(k + 1), 1, 0, 0);
    drive(0, '0, 1, 1, 0);
    check_eq("t1_word0", cut_data[DW-1:0], 8'd1);
    check_eq("t1_word47", cut_data[CUT_W-1 -: DW], 8'd48);

    // Overrun on a full frame, then clear
    for (int k = 0; k < D; k++) drive(1, DW'($urandom), 1, 0, 0);
    drive(1, 8'hAA, 1, 0, 0);
    check_eq("t2_overrun", overrun, 1);
    drive(0, '0, 1, 0, 1);

    // Load and accept in the same cycle; the next frame carries 0x55 in slot 0
    drive(1, 8'h55, 1, 1, 0);
    check_eq("t3_word_cnt", word_cnt, 1);
    for (int k = 1; k < D; k++) drive(1, DW'($urandom), 1, 0, 0);
    drive(0, '0, 1, 1, 0);
    check_eq("t3_shadow0", cut_data[DW-1:0], 8'h55);

    // re_i low mid-frame drops the word
    for (int k = 0; k < 10; k++) drive(1, DW'($urandom), 1, 0, 0);
    drive(1, 8'h3C, 0, 0, 0);
    check_eq("t4_word_cnt", word_cnt, 10);
    drive(0, '0, 1, 0, 1);

    // Reset at word 20, then a fresh complete frame
    for (int k = 10; k < 20; k++) drive(1, DW'($urandom), 1, 0, 0);
    do_reset();
    for (int k = 0; k < D; k++) drive(1, DW'($urandom), 1, 0, 0);
    drive(0, '0, 1, 1, 0);

    // Randomized back-to-back frames with gaps, stray words and an early load
    for (int f = 0; f < 5; f++) begin
      guard = 0;
      while (!m_full && guard < 2000) begin
        drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) != 0,
              (f == 2 && guard == 7), $urandom_range(0, 9) == 0);
        guard++;
      end
      check_eq("frame_complete", m_full, 1);
      for (int g = 0; g < int'($urandom_range(1, 5)); g++)
        drive($urandom_range(0, 3) == 0, DW'($urandom), 0, 0, 0);
      drive($urandom_range(0, 1) == 1, DW'($urandom), 1, 1, 0);
      drive(0, '0, 1, 0, 1);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
